// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus sequencer and the CPU core that issues its requests.
package ram_bus_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int RD_WAIT_DEF = 1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_RD        = 3'd1;
    localparam logic [ST_W-1:0] ST_WR_SETUP  = 3'd2;
    localparam logic [ST_W-1:0] ST_WR_STROBE = 3'd3;
    localparam logic [ST_W-1:0] ST_WR_HOLD   = 3'd4;

    // Field widths the CPU side packs its request/response buses with.
    localparam int REQ_W = 1 + ADDR_W_DEF + DATA_W_DEF;
    localparam int RSP_W = 1 + DATA_W_DEF;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } ram_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] rdata;
    } ram_rsp_t;

endpackage

// File: rtl/ram_bus_ctrl.sv
// Sequences CPU load/store requests into ena/read/write strobes for the 1Kx8 ram macro.
module ram_bus_ctrl
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [2:0] RD_WAIT_C = 3'(RD_WAIT);

    logic [ST_W-1:0]   state;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              data_oe;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Bus released whenever the output enable flop is low, including asynchronously on reset.
    assign ram_data = data_oe ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            wdata_q   <= '0;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_ena   <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ram_ena   <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    data_oe   <= 1'b0;
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        wdata_q  <= req_wdata;
                        ram_ena  <= 1'b1;
                        if (req_we) begin
                            data_oe <= 1'b1;
                            state   <= ST_WR_SETUP;
                        end else begin
                            ram_read <= 1'b1;
                            wait_cnt <= RD_WAIT_C;
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (wait_cnt == 3'd0) begin
                        rsp_rdata <= ram_data;
                        rsp_valid <= 1'b1;
                        ram_ena   <= 1'b0;
                        ram_read  <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_WR_SETUP: begin
                    ram_write <= 1'b1;
                    state     <= ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    ram_write <= 1'b0;
                    state     <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    data_oe   <= 1'b0;
                    ram_ena   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    data_oe   <= 1'b0;
                    ram_ena   <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    a_no_contention: assert property (@(posedge clk) disable iff (!rst_n) !(ram_read && data_oe));

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Scoreboard bench for ram_bus_ctrl with a behavioural 1Kx8 RAM on the shared data bus.
module tb_ram_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, busy, ram_ena, ram_read, ram_write;
    logic [7:0] rsp_rdata;
    logic [9:0] ram_addr;
    wire  [7:0] ram_data;

    logic       req_valid3 = 1'b0;
    logic [9:0] req_addr3 = '0;
    logic       req_ready3, rsp_valid3, busy3, ram_ena3, ram_read3, ram_write3;
    logic [7:0] rsp_rdata3;
    logic [9:0] ram_addr3;
    wire  [7:0] ram_data3;

    ram_bus_ctrl #(.ADDR_W(10), .DATA_W(8), .RD_WAIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    ram_bus_ctrl #(.ADDR_W(10), .DATA_W(8), .RD_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(1'b0), .req_addr(req_addr3), .req_wdata(8'h00),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .busy(busy3),
        .ram_ena(ram_ena3), .ram_read(ram_read3), .ram_write(ram_write3),
        .ram_addr(ram_addr3), .ram_data(ram_data3)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read while ena&read, capture on rising write.
    logic [7:0] mem [1024];
    int         wr_edges = 0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    assign ram_data  = (ram_ena && ram_read) ? mem[ram_addr] : 8'bz;
    assign ram_data3 = (ram_ena3 && ram_read3) ? (ram_addr3[7:0] ^ 8'h5A) : 8'bz;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hC3;
        forever begin
            @(posedge ram_write);
            wr_edges = wr_edges + 1;
            wr_addr  = ram_addr;
            wr_data  = ram_data;
            if (ram_ena) mem[ram_addr] = ram_data;
        end
    end

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rdata;
        int         lat;
        int         acc;
    } sb_t;
    sb_t        sb[$];
    logic [7:0] shadow [1024];
    logic [7:0] last_rd = 8'h00;

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                sb_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [9:0] a, input logic [7:0] d,
                         input bit push, output int acc);
        int  g = 0;
        sb_t e;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        if (push) begin
            e.acc = acc;
            if (we) begin
                shadow[a] = d;
                e.rdata = last_rd;
                e.lat = 3;
            end else begin
                e.rdata = shadow[a];
                last_rd = shadow[a];
                e.lat = 2;
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic load3(input logic [9:0] a);
        int rd_cnt = 0, lat = -1;
        req_valid3 = 1'b1; req_addr3 = a;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(negedge clk);
        if (ram_read3) rd_cnt++;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (ram_read3) rd_cnt++;
            if (rsp_valid3) begin lat = n; break; end
        end
        chk("rw3_latency", 32'(lat), 32'd4);
        chk("rw3_read_cycles", 32'(rd_cnt), 32'd4);
        chk("rw3_rdata", 32'(rsp_rdata3), 32'(a[7:0] ^ 8'h5A));
    endtask

    initial begin
        int a0, a1, w0;
        for (int i = 0; i < 1024; i++) shadow[i] = 8'(i) ^ 8'hC3;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_strobes", {29'd0, ram_ena, ram_read, ram_write}, 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Store 005 <- A5 with cycle-by-cycle strobe checks.
        w0 = wr_edges;
        issue(1'b1, 10'h005, 8'hA5, 1'b1, a0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("setup_bus", {ram_ena, ram_read, ram_write, ram_addr, ram_data}, {3'b100, 10'h005, 8'hA5});
        @(negedge clk);
        chk("strobe_bus", {ram_ena, ram_read, ram_write, ram_addr, ram_data}, {3'b101, 10'h005, 8'hA5});
        @(negedge clk);
        chk("hold_bus", {ram_ena, ram_read, ram_write, ram_addr, ram_data}, {3'b100, 10'h005, 8'hA5});
        wait_done();
        chk("st_write_edges", 32'(wr_edges - w0), 32'd1);
        chk("st_write_capture", {wr_addr, wr_data}, {10'h005, 8'hA5});
        @(negedge clk);
        chk("idle_ena", 32'(ram_ena), 32'd0);

        // Load it back.
        issue(1'b0, 10'h005, 8'h00, 1'b1, a0);
        req_valid = 1'b0;
        wait_done();

        // Back-to-back store/load on the top address.
        issue(1'b1, 10'h3FF, 8'h3C, 1'b1, a0);
        issue(1'b0, 10'h3FF, 8'h00, 1'b1, a1);
        req_valid = 1'b0;
        chk("b2b_gap", 32'(a1 - a0), 32'd4);
        wait_done();

        // Request fields change while busy; only the first store lands.
        w0 = wr_edges;
        issue(1'b1, 10'h010, 8'h11, 1'b1, a0);
        req_addr = 10'h2AB; req_wdata = 8'hEE;
        @(posedge clk); #1;
        req_addr = 10'h155; req_wdata = 8'h44;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done();
        chk("busy_edges", 32'(wr_edges - w0), 32'd1);
        chk("busy_capture", {wr_addr, wr_data}, {10'h010, 8'h11});
        chk("busy_mem_2ab", 32'(mem[10'h2AB]), 32'(shadow[10'h2AB]));
        chk("busy_mem_155", 32'(mem[10'h155]), 32'(shadow[10'h155]));
        issue(1'b0, 10'h010, 8'h00, 1'b1, a0);
        req_valid = 1'b0;
        wait_done();

        // Reset pulse while in WR_SETUP aborts the store.
        w0 = wr_edges;
        issue(1'b1, 10'h020, 8'h99, 1'b0, a0);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes", {29'd0, ram_ena, ram_read, ram_write}, 32'd0);
        chk("abort_ready_busy", {30'd0, req_ready, busy}, 32'd2);
        chk("abort_rsp", {23'd0, rsp_valid, rsp_rdata}, 32'd0);
        chk("abort_addr", 32'(ram_addr), 32'd0);
        last_rd = 8'h00;
        #5 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_edges", 32'(wr_edges - w0), 32'd0);
        chk("abort_mem", 32'(mem[10'h020]), 32'(shadow[10'h020]));
        issue(1'b0, 10'h020, 8'h00, 1'b1, a0);
        req_valid = 1'b0;
        wait_done();

        // RD_WAIT=3 instance.
        load3(10'h0F3);
        load3(10'h200);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ram_bus_ctrl.md
# ram_bus_ctrl

Memory-side bus sequencer sitting directly upstream of the 1K×8 `ram` macro. It turns single-cycle CPU load/store requests (valid/ready) into correctly ordered `ena`/`read`/`write` strobes, drives and releases the bidirectional data bus, and returns read data. The write strobe is a clean registered pulse because `ram` captures on the rising edge of `write`.

## Interface
- `ADDR_W`, 10: address width, matching the RAM depth of 1024.
- `DATA_W`, 8: data width.
- `RD_WAIT`, 1: extra read-access cycles before sampling; legal range 0..7.

- `clk`  in  1  single system clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  one-cycle completion pulse for both loads and stores.
- `rsp_rdata`  out  DATA_W  load data; holds its last value otherwise.
- `busy`  out  1  high in every non-IDLE state.
- `ram_ena`  out  1  to RAM `ena`.
- `ram_read`  out  1  to RAM `read`.
- `ram_write`  out  1  to RAM `write`; registered, glitch-free.
- `ram_addr`  out  ADDR_W  to RAM `addr`; latched at accept.
- `ram_data`  inout  DATA_W  to RAM `data`; driven only while writing, otherwise Z.

## Operation
- Accept when `req_valid && req_ready` at a clock edge. Latch `req_addr`, `req_we` and `req_wdata`.
- States: IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD.
- IDLE → RD if `we`=0. IDLE → WR_SETUP if `we`=1.
- RD:
  - `ram_ena`=1, `ram_read`=1, bus not driven.
  - A wait counter runs for 1+RD_WAIT cycles.
  - On the final edge, sample `ram_data` into `rsp_rdata`, pulse `rsp_valid`, go to IDLE.
- WR_SETUP:
  - `ram_ena`=1, `ram_read`=0, `ram_write`=0.
  - Drive `ram_data`=wdata and `ram_addr` for one cycle.
- WR_STROBE: `ram_write`=1 for exactly one cycle; data and address are held.
- WR_HOLD:
  - `ram_write`=0; data is still driven for one cycle.
  - Then go to IDLE with a `rsp_valid` pulse. `rsp_rdata` is unchanged.
- Contention rule: `ram_read` and the bus output enable are never high in the same cycle. Any state where both would be high is an assertion failure.
- `ram_ena` falls to 0 in IDLE. Address is held until the next accept.
- `req_*` inputs are ignored while `busy`; there is no queuing.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0.
  - `ram_ena`/`ram_read`/`ram_write`=0, `ram_addr`=0, bus Z.
- All RAM-side outputs come directly from flops; there is no combinational path from `req_*` to `ram_*`.
- Load latency: accept at edge E0; `rsp_valid` is high in the cycle after edge E(1+RD_WAIT). With RD_WAIT=1 that is 2 edges.
- Store latency: accept E0; `ram_write` rises after E1 and falls after E2; `rsp_valid` is high after E3.
- `req_ready` returns to 1 in the same cycle `rsp_valid` is high. Back-to-back requests therefore lose no cycle.
- Reset asserted mid-operation:
  - All strobes drop and the bus goes Z asynchronously.
  - No `rsp_valid` is issued for the aborted request.
  - A store aborted before WR_STROBE must not reach the RAM.

## Structure
- Shared package `ram_bus_pkg`:
  - State enum encoding.
  - Default `ADDR_W`, `DATA_W`, `RD_WAIT` constants.
  - Request/response field widths reused by the CPU core.
- Single module; no sub-module is warranted. The tri-state is one continuous assign gated by a registered output-enable.

## Test plan
- Reset, then store addr 10'h005 data 8'hA5:
  - exactly one `ram_write` rising edge, with `ram_addr`=005 and `ram_data`=A5 stable one cycle before and after;
  - `rsp_valid` after E3.
- Load addr 10'h005 after that store, RD_WAIT=1: `rsp_valid` after E2 with `rsp_rdata`=8'hA5; bus Z throughout.
- Back-to-back: store 3FF←8'h3C, then immediately load 3FF:
  - second accept in the `rsp_valid` cycle of the first;
  - read returns 3C;
  - no cycle with read and output enable both high.
- `req_valid` held high with changing addr/data while `busy`: ignored, and the RAM sees only the first request.
- `rst_n` pulsed low during WR_SETUP:
  - no `ram_write` edge;
  - the RAM location keeps its old value;
  - outputs return to reset values immediately.
- RD_WAIT=3: load latency is 4 edges, and `ram_read` is high for exactly 4 cycles.
